reg_file_2r1w: RTL and testbench
================================

Name: reg_file_2r1w

Overview:
- Register file built from a bank of loadable N-bit registers, one per address, each made of REG1-style cells.
- Its write-address decoder generates the per-register load enables, and two read-port multiplexers consume the registers' Q outputs.
- It is the next stage around the register bank and feeds ALU operands in the datapath.
- Two registered read ports, one synchronous write port.
- Register 0 is hardwired to zero.

Parameters:
DATA_WIDTH, 32, width of each register and of every data port
ADDR_WIDTH, 5, width of each address port
REG_COUNT, 32, number of registers (must equal 2**ADDR_WIDTH)
BYPASS, 1, 1 = same-edge write data forwarded to read outputs; 0 = read returns pre-write value

Ports:
C  input  1  clock; all state updates on rising edge
nR  input  1  reset, asynchronous, active-low
READ  input  1  read strobe; read outputs update only when 1
WRITE  input  1  write strobe
ADDR_R1  input  ADDR_WIDTH  read port 1 address
ADDR_R2  input  ADDR_WIDTH  read port 2 address
ADDR_W  input  ADDR_WIDTH  write address
DATA_W  input  DATA_WIDTH  write data
DATA_R1  output  DATA_WIDTH  read port 1 data (registered)
DATA_R2  output  DATA_WIDTH  read port 2 data (registered)

Behaviour:
- Clock and reset:
  - One clock, C.
  - Reset nR is asynchronous and active-low.
  - While nR=0, all REG_COUNT registers, DATA_R1 and DATA_R2 are forced to 0 immediately, independent of C.
- Reset release: the first rising edge after nR returns to 1 operates normally. No extra idle cycle is required.
- Reset mid-operation: a write or read in flight is discarded. Nothing resumes after release.
- Write:
  - On a rising edge of C with WRITE=1 and ADDR_W!=0, register[ADDR_W] <= DATA_W.
  - Only the decoded register's load enable is asserted; all others hold.
- Register 0: writes to address 0 are silently ignored. Register 0 always reads 0.
- Read:
  - On a rising edge of C with READ=1: DATA_R1 <= value(ADDR_R1) and DATA_R2 <= value(ADDR_R2).
  - Latency is 1 edge: the value is visible after the edge at which READ was sampled.
- Hold:
  - READ=0: DATA_R1 and DATA_R2 hold their last values, regardless of writes.
  - READ=0 and WRITE=0: no state change at all.
- Simultaneous READ=1 and WRITE=1 to the same non-zero address on the same edge:
  - BYPASS=1: the read output gets DATA_W.
  - BYPASS=0: the read output gets the register's pre-edge value; the register still takes DATA_W.
  - Applies to each port independently; both ports may hit the write address at once.
- Simultaneous read and write to different addresses: both complete on the same edge with no interaction.
- X on the address or data inputs while the corresponding strobe is 0 must not change state or outputs.
- No combinational path exists from any input to DATA_R1 or DATA_R2; outputs change only on a C edge or on nR.
- Width rules:
  - Addresses are used unsigned, full width. With REG_COUNT=2**ADDR_WIDTH there are no out-of-range addresses.
  - No arithmetic is performed.

Test Plan:
1. Reset: drive nR=0 mid-cycle after writing 0xDEADBEEF to r5. DATA_R1/DATA_R2 go to 0 without a clock edge. After release, a read of r5 returns 0x00000000.
2. Write/read: write r3=0x12345678 and r31=0xFFFFFFFF on separate edges, then READ with ADDR_R1=3, ADDR_R2=31. One edge later DATA_R1=0x12345678 and DATA_R2=0xFFFFFFFF.
3. Register 0: WRITE=1, ADDR_W=0, DATA_W=0xA5A5A5A5, then read ADDR_R1=0 and ADDR_R2=0. Both outputs are 0x00000000.
4. Hold: after test 2, set READ=0, write r3=0x0 and change ADDR_R1 to 7. DATA_R1 stays 0x12345678 until the next READ=1 edge.
5. Same-edge collision: r9 holds 0x11111111, then one edge with WRITE=1, READ=1, ADDR_W=ADDR_R1=ADDR_R2=9, DATA_W=0x22222222.
   - BYPASS=1: both outputs are 0x22222222.
   - BYPASS=0: both outputs are 0x11111111, and a follow-up read returns 0x22222222.
6. Sweep: write register i with value i*0x01010101 for i=1..31, then read all pairs (i, 31-i). Every read matches, and r0 reads 0.

Source files
------------

// File: rtl/reg_file_2r1w.sv
// Two-read / one-write register file with registered read ports.
// Register 0 is hardwired to zero; the others are loadable N-bit registers
// whose load enables come from a write-address decoder. Optional same-edge
// write-to-read forwarding is selected by BYPASS.
module reg_file_2r1w #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int REG_COUNT  = 32,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  C,
  input  logic                  nR,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] ADDR_R1,
  input  logic [ADDR_WIDTH-1:0] ADDR_R2,
  input  logic [ADDR_WIDTH-1:0] ADDR_W,
  input  logic [DATA_WIDTH-1:0] DATA_W,
  output logic [DATA_WIDTH-1:0] DATA_R1,
  output logic [DATA_WIDTH-1:0] DATA_R2
);

  // Current contents of every register as seen by the read multiplexers.
  logic [DATA_WIDTH-1:0] regVal [REG_COUNT];

  logic [DATA_WIDTH-1:0] dataR1_d;
  logic [DATA_WIDTH-1:0] dataR2_d;
  logic [DATA_WIDTH-1:0] dataR1_q;
  logic [DATA_WIDTH-1:0] dataR2_q;

  for (genvar g = 0; g < REG_COUNT; g++) begin : gReg
    if (g == 0) begin : gZero
      assign regVal[g] = '0;
    end else begin : gCell
      logic                  loadEn;
      logic [DATA_WIDTH-1:0] data_q;

      assign loadEn = WRITE && (ADDR_W == ADDR_WIDTH'(g));

      // Loadable register cell: takes DATA_W only when its address is decoded.
      always_ff @(posedge C or negedge nR) begin
        if (!nR) begin
          data_q <= '0;
        end else if (loadEn) begin
          data_q <= DATA_W;
        end
      end

      assign regVal[g] = data_q;
    end
  end

  // Read multiplexers, with optional forwarding of a same-edge write
  // (never for address 0, whose writes are discarded).
  always_comb begin
    dataR1_d = regVal[ADDR_R1];
    dataR2_d = regVal[ADDR_R2];
    if (BYPASS && WRITE && (ADDR_R1 == ADDR_W) && (ADDR_R1 != '0)) begin
      dataR1_d = DATA_W;
    end
    if (BYPASS && WRITE && (ADDR_R2 == ADDR_W) && (ADDR_R2 != '0)) begin
      dataR2_d = DATA_W;
    end
  end

  // Registered read ports: update only on READ, otherwise hold.
  always_ff @(posedge C or negedge nR) begin
    if (!nR) begin
      dataR1_q <= '0;
      dataR2_q <= '0;
    end else if (READ) begin
      dataR1_q <= dataR1_d;
      dataR2_q <= dataR2_d;
    end
  end

  assign DATA_R1 = dataR1_q;
  assign DATA_R2 = dataR2_q;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed testbench for reg_file_2r1w. Two instances share all inputs:
// one with same-edge forwarding, one without.
module tb_reg_file_2r1w;

  logic        C;
  logic        nR;
  logic        READ;
  logic        WRITE;
  logic [4:0]  ADDR_R1;
  logic [4:0]  ADDR_R2;
  logic [4:0]  ADDR_W;
  logic [31:0] DATA_W;
  logic [31:0] byR1, byR2, nbR1, nbR2;

  int checks;
  int errors;

  reg_file_2r1w #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .REG_COUNT(32), .BYPASS(1'b1)) dutBypass (
    .C(C), .nR(nR), .READ(READ), .WRITE(WRITE),
    .ADDR_R1(ADDR_R1), .ADDR_R2(ADDR_R2), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .DATA_R1(byR1), .DATA_R2(byR2)
  );

  reg_file_2r1w #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .REG_COUNT(32), .BYPASS(1'b0)) dutNoBypass (
    .C(C), .nR(nR), .READ(READ), .WRITE(WRITE),
    .ADDR_R1(ADDR_R1), .ADDR_R2(ADDR_R2), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .DATA_R1(nbR1), .DATA_R2(nbR2)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial C = 1'b0;
  always #5 C = ~C;

  // Drive one cycle of inputs on the falling edge, then settle just past the rising edge.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [4:0] ar1,
                               input logic [4:0] ar2, input logic [4:0] aw, input logic [31:0] dw);
    @(negedge C);
    READ    = rd;
    WRITE   = wr;
    ADDR_R1 = ar1;
    ADDR_R2 = ar2;
    ADDR_W  = aw;
    DATA_W  = dw;
    @(posedge C);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [31:0] e1, input logic [31:0] e2);
    checkOutput({tag, " bypass R1"}, byR1, e1);
    checkOutput({tag, " bypass R2"}, byR2, e2);
    checkOutput({tag, " nobypass R1"}, nbR1, e1);
    checkOutput({tag, " nobypass R2"}, nbR2, e2);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    nR      = 1'b0;
    READ    = 1'b0;
    WRITE   = 1'b0;
    ADDR_R1 = '0;
    ADDR_R2 = '0;
    ADDR_W  = '0;
    DATA_W  = '0;

    // Reset state
    repeat (2) @(posedge C);
    #1;
    checkAll("reset", 32'h0, 32'h0);
    @(negedge C);
    nR = 1'b1;

    // Async reset mid-cycle discards r5 and clears the outputs without an edge
    applyStimulus(1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b0, 5'd5, 5'd5, 5'd0, 32'h0);
    checkAll("r5 before reset", 32'hDEADBEEF, 32'hDEADBEEF);
    READ  = 1'b0;
    WRITE = 1'b0;
    #2;
    nR = 1'b0;
    #1;
    checkAll("async reset", 32'h0, 32'h0);
    #3;
    nR = 1'b1;
    applyStimulus(1'b1, 1'b0, 5'd5, 5'd5, 5'd0, 32'h0);
    checkAll("r5 after reset", 32'h0, 32'h0);

    // Write then read on separate edges
    applyStimulus(1'b0, 1'b1, 5'd0, 5'd0, 5'd3, 32'h12345678);
    applyStimulus(1'b0, 1'b1, 5'd0, 5'd0, 5'd31, 32'hFFFFFFFF);
    applyStimulus(1'b1, 1'b0, 5'd3, 5'd31, 5'd0, 32'h0);
    checkAll("read r3 r31", 32'h12345678, 32'hFFFFFFFF);

    // Hold while READ=0 even though r3 is rewritten and the address moves
    applyStimulus(1'b0, 1'b1, 5'd7, 5'd31, 5'd3, 32'h0);
    checkAll("hold", 32'h12345678, 32'hFFFFFFFF);
    applyStimulus(1'b0, 1'b0, 5'bx, 5'bx, 5'bx, 32'hx);
    checkAll("hold idle x", 32'h12345678, 32'hFFFFFFFF);
    applyStimulus(1'b1, 1'b0, 5'd3, 5'd31, 5'd0, 32'h0);
    checkAll("reread r3", 32'h0, 32'hFFFFFFFF);

    // Register 0 ignores writes, also as a same-edge collision
    applyStimulus(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'hA5A5A5A5);
    applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    checkAll("r0 read", 32'h0, 32'h0);
    applyStimulus(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 32'hA5A5A5A5);
    checkAll("r0 collide", 32'h0, 32'h0);

    // Same-edge collision on r9: forwarding instance sees new data, the other old
    applyStimulus(1'b0, 1'b1, 5'd0, 5'd0, 5'd9, 32'h11111111);
    applyStimulus(1'b1, 1'b1, 5'd9, 5'd9, 5'd9, 32'h22222222);
    checkOutput("collide bypass R1", byR1, 32'h22222222);
    checkOutput("collide bypass R2", byR2, 32'h22222222);
    checkOutput("collide nobypass R1", nbR1, 32'h11111111);
    checkOutput("collide nobypass R2", nbR2, 32'h11111111);
    applyStimulus(1'b1, 1'b0, 5'd9, 5'd9, 5'd0, 32'h0);
    checkAll("collide followup", 32'h22222222, 32'h22222222);

    // Read and write to different addresses on the same edge
    applyStimulus(1'b1, 1'b1, 5'd31, 5'd9, 5'd4, 32'h44444444);
    checkAll("rw different", 32'hFFFFFFFF, 32'h22222222);
    applyStimulus(1'b1, 1'b0, 5'd4, 5'd3, 5'd0, 32'h0);
    checkAll("read r4", 32'h44444444, 32'h0);

    // Sweep: r[i] = i * 0x01010101, then read pairs (i, 31-i)
    for (int i = 1; i < 32; i++) begin
      applyStimulus(1'b0, 1'b1, 5'd0, 5'd0, 5'(i), 32'(i) * 32'h01010101);
    end
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, 1'b0, 5'(i), 5'(31 - i), 5'd0, 32'h0);
      checkAll($sformatf("sweep %0d", i), 32'(i) * 32'h01010101, 32'(31 - i) * 32'h01010101);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
